// File: rtl/fp_sqrt_sig_iter_pkg.sv
// Shared types and default sizing for the iterative significand square-root engine.
package fp_sqrt_sig_iter_pkg;

  localparam int unsigned default_sig_width = 23;
  localparam int unsigned default_tag_width = 12;

  // IEEE rounding modes carried in the sideband tag.
  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } round_t;

  // Engine control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_t;

endpackage

// File: rtl/fp_sqrt_sig_iter_if.sv
// Operand/result handshake bundle for fp_sqrt_sig_iter.
interface fp_sqrt_sig_iter_if
  import fp_sqrt_sig_iter_pkg::*;
#(
  parameter int unsigned sig_width = default_sig_width,
  parameter int unsigned tag_width = default_tag_width
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [sig_width-1:0] a_sig;
  logic                 a_exp_lsb;
  logic [tag_width-1:0] tag_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [sig_width+2:0] z_sig_nr;
  logic [tag_width-1:0] tag_out;

  // Upstream producer / downstream consumer side.
  modport master (
    output in_valid, a_sig, a_exp_lsb, tag_in, out_ready,
    input  in_ready, out_valid, z_sig_nr, tag_out
  );

  // Engine side.
  modport slave (
    input  in_valid, a_sig, a_exp_lsb, tag_in, out_ready,
    output in_ready, out_valid, z_sig_nr, tag_out
  );

endinterface

// File: rtl/fp_sqrt_sig_iter_sqrt_rec_step.sv
// One restoring square-root iteration: brings in two radicand bits and
// decides one root bit.
module sqrt_rec_step #(
  parameter int unsigned n = 25
) (
  input  logic [n+1:0] rem,
  input  logic [n-1:0] q,
  input  logic [1:0]   pair,
  output logic [n+1:0] rem_next,
  output logic         q_bit
);

  logic [n+2:0] rem_sh;
  logic [n+2:0] trial;
  logic         unused_rem_msb;

  // The live remainder never exceeds n+1 bits before shifting, so the top
  // register bit drops out and one extra bit above n+2 serves as the sign.
  assign unused_rem_msb = rem[n+1];

  // Trial subtraction of {Q, 01}; keep it when non-negative.
  always_comb begin
    rem_sh   = {rem[n:0], pair};
    trial    = rem_sh - {1'b0, q, 2'b01};
    q_bit    = ~trial[n+2];
    rem_next = q_bit ? trial[n+1:0] : rem_sh[n+1:0];
  end

endmodule

// File: rtl/fp_sqrt_sig_iter.sv
// Multi-cycle one-bit-per-cycle significand square root with tag pass-through.
module fp_sqrt_sig_iter
  import fp_sqrt_sig_iter_pkg::*;
#(
  parameter int unsigned sig_width = default_sig_width,
  parameter int unsigned tag_width = default_tag_width
) (
  input logic              clk,
  input logic              resetn,
  input logic              enable,
  fp_sqrt_sig_iter_if.slave bus
);

  localparam int unsigned n     = sig_width + 2;
  localparam int unsigned cnt_w = $clog2(n);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(n - 1);

  sqrt_state_t          state;
  logic [cnt_w-1:0]     cnt;
  logic [2*n-1:0]       rad;
  logic [2*n-1:0]       rad_in;
  logic [n-1:0]         q;
  logic [n+1:0]         rem;
  logic [n+1:0]         rem_next;
  logic                 q_bit;
  logic [n-1:0]         q_next;
  logic [tag_width-1:0] tag_hold;
  logic [n:0]           z_reg;
  logic [tag_width-1:0] tag_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;

  // Radicand: {1,frac} scaled so the root lands with its MSB at bit n-1;
  // an even biased exponent (odd unbiased) doubles the significand first.
  always_comb begin
    rad_in = {{(n+1){1'b0}}, 1'b1, bus.a_sig};
    rad_in = bus.a_exp_lsb ? (rad_in << n) : (rad_in << (n + 1));
  end

  sqrt_rec_step #(.n(n)) u_step (
    .rem      (rem),
    .q        (q),
    .pair     (rad[2*n-1 -: 2]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign q_next = {q[n-2:0], q_bit};

  // Control FSM, recurrence registers and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cnt           <= '0;
      rad           <= '0;
      q             <= '0;
      rem           <= '0;
      tag_hold      <= '0;
      z_reg         <= '0;
      tag_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            rad          <= rad_in;
            q            <= '0;
            rem          <= '0;
            tag_hold     <= bus.tag_in;
            cnt          <= cnt_last;
            in_ready_reg <= 1'b0;
            state        <= CALC;
          end
        end
        CALC: begin
          rad <= {rad[2*n-3:0], 2'b00};
          q   <= q_next;
          rem <= rem_next;
          if (cnt == '0) begin
            z_reg         <= {q_next, |rem_next};
            tag_reg       <= tag_hold;
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - cnt_w'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.z_sig_nr  = z_reg;
  assign bus.tag_out   = tag_reg;

endmodule

// File: tb/tb_fp_sqrt_sig_iter.sv
// Self-checking bench for fp_sqrt_sig_iter (binary32 sizing).
module tb_fp_sqrt_sig_iter;

  localparam int unsigned SW = 23;
  localparam int unsigned TW = 12;
  localparam int unsigned N  = SW + 2;

  typedef struct {
    logic [SW+2:0] z;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b1;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fp_sqrt_sig_iter_if #(.sig_width(SW), .tag_width(TW)) bus ();

  fp_sqrt_sig_iter #(.sig_width(SW), .tag_width(TW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .enable (enable),
    .bus    (bus.slave)
  );

  // Reference: integer square root by binary search over the radicand.
  function automatic logic [SW+2:0] model(input logic [SW-1:0] s, input logic e);
    longint unsigned m, r, lo, hi, mid;
    logic [SW+2:0] res;
    m  = 64'h80_0000 | 64'(s);
    r  = e ? (m << 25) : (m << 26);
    lo = 0;
    hi = 64'd1 << 26;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= r) lo = mid;
      else hi = mid;
    end
    res = {lo[24:0], (lo * lo != r)};
    return res;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SW-1:0] s, input logic e, input logic [TW-1:0] t);
    int unsigned k = 0;
    bit ok = 1'b0;
    exp_t x;
    bus.in_valid  = 1'b1;
    bus.a_sig     = s;
    bus.a_exp_lsb = e;
    bus.tag_in    = t;
    while (!ok && k < 200) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1 && enable === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        k++;
      end
    end
    bus.in_valid = 1'b0;
    if (ok) begin
      x.z   = model(s, e);
      x.tag = t;
      sb.push_back(x);
    end
    check("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic drain(input bit rnd);
    int unsigned k = 0;
    while (sb.size() != 0 && k < 3000) begin
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      k++;
    end
    bus.out_ready = 1'b0;
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_valid();
    int unsigned k = 0;
    while (bus.out_valid !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check("valid_timeout", 64'(bus.out_valid), 64'd1);
  endtask

  // Scoreboard: compare each result at the edge where its handshake completes.
  always @(negedge clk) begin
    if (resetn === 1'b1 && enable === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_underflow observed z=%h with no expected entry", bus.z_sig_nr);
      end else begin
        mon_e = sb.pop_front();
        check("res_z", 64'(bus.z_sig_nr), 64'(mon_e.z));
        check("res_tag", 64'(bus.tag_out), 64'(mon_e.tag));
      end
    end
  end

  initial begin
    int unsigned cyc;
    logic [SW-1:0] rs;
    logic re;

    bus.in_valid  = 1'b0;
    bus.a_sig     = '0;
    bus.a_exp_lsb = 1'b0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_z", 64'(bus.z_sig_nr), 64'd0);
    check("rst_tag", 64'(bus.tag_out), 64'd0);
    resetn = 1'b1;
    step();

    // sqrt(1.0) with exact latency
    send(23'h0, 1'b1, 12'hA51);
    repeat (N - 1) step();
    check("lat_early", 64'(bus.out_valid), 64'd0);
    step();
    check("lat_on", 64'(bus.out_valid), 64'd1);
    check("sqrt1_z", 64'(bus.z_sig_nr), 64'h2000000);
    check("sqrt1_tag", 64'(bus.tag_out), 64'hA51);
    drain(1'b0);

    // sqrt(2.0) held under backpressure, second operand waiting
    send(23'h0, 1'b0, 12'h3C7);
    wait_valid();
    check("sqrt2_z", 64'(bus.z_sig_nr), 64'h2D413CD);
    bus.in_valid  = 1'b1;
    bus.a_sig     = 23'h100000;
    bus.a_exp_lsb = 1'b0;
    bus.tag_in    = 12'h5E2;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_z", 64'(bus.z_sig_nr), 64'h2D413CD);
      check("bp_tag", 64'(bus.tag_out), 64'h3C7);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("bp_released", 64'(bus.out_valid), 64'd0);
    check("bp_ready_after", 64'(bus.in_ready), 64'd1);
    mon_e.z   = model(23'h100000, 1'b0);
    mon_e.tag = 12'h5E2;
    sb.push_back(mon_e);
    step();
    bus.in_valid = 1'b0;
    check("second_accepted", 64'(bus.in_ready), 64'd0);
    wait_valid();
    check("sqrt225_z", 64'(bus.z_sig_nr), 64'h3000000);
    drain(1'b0);

    // Boundary radicands: all-ones fraction for both exponent parities
    send('1, 1'b1, 12'h001);
    drain(1'b0);
    send('1, 1'b0, 12'h002);
    drain(1'b0);

    // Stall of 5 cycles in the middle of the recurrence
    send(23'h2AAAAA, 1'b1, 12'h777);
    cyc = 0;
    repeat (8) begin step(); cyc++; end
    enable = 1'b0;
    repeat (5) begin step(); cyc++; end
    enable = 1'b1;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    check("stall_latency", 64'(cyc), 64'(N + 5));
    drain(1'b0);

    // Asynchronous reset in the middle of the recurrence
    send(23'h123456, 1'b0, 12'hBEE);
    repeat (10) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_z", 64'(bus.z_sig_nr), 64'd0);
    check("arst_tag", 64'(bus.tag_out), 64'd0);
    sb.delete();
    step();
    resetn = 1'b1;
    step();
    check("arst_release_ready", 64'(bus.in_ready), 64'd1);
    send(23'h654321, 1'b1, 12'hCAB);
    drain(1'b0);

    // Random regression with random backpressure
    for (int i = 0; i < 300; i++) begin
      rs = SW'($urandom);
      re = 1'($urandom_range(0, 1));
      send(rs, re, TW'(i));
      drain(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
